// File: rtl/gcd_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_dispatch
//  Purpose  : Queues 8-bit operand pairs in a small circular FIFO and issues
//             them one at a time to a downstream GCD core. The result (or an
//             error) is held on the output until the consumer takes it.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, RST               clock, synchronous active-high reset
//    IN_VALID/IN_READY      operand handshake, IN_A/IN_B operand pair
//    PENDING                FIFO occupancy (0..DEPTH)
//    GCD_START              one-cycle start pulse, GCD_A/GCD_B operands
//    GCD_DONE/GCD_Y         core result pulse and value
//    GCD_ERROR              core error flag, valid with GCD_DONE
//    OUT_VALID/OUT_READY    result handshake, OUT_Y value, OUT_ERR error,
//                           OUT_TMO error caused by a core timeout
//  Configuration
//    GCD_DISPATCH_TIMEOUT_EN  when defined, a WAIT that lasts 255 cycles
//                             without GCD_DONE ends in a timeout result.
//                             Undefined: WAIT is unbounded, OUT_TMO is 0.
// ============================================================================
module gcd_dispatch #(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic [7:0] IN_A,
    input  logic [7:0] IN_B,
    output logic       IN_READY,
    output logic       GCD_START,
    output logic [7:0] GCD_A,
    output logic [7:0] GCD_B,
    input  logic [7:0] GCD_Y,
    input  logic       GCD_DONE,
    input  logic       GCD_ERROR,
    output logic       OUT_VALID,
    output logic [7:0] OUT_Y,
    output logic       OUT_ERR,
    output logic       OUT_TMO,
    input  logic       OUT_READY,
    output logic [4:0] PENDING
);

    localparam int         c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] c_DEPTH = 5'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic [7:0]      r_mem_a [DEPTH];
    logic [7:0]      r_mem_b [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [4:0]      r_count;

    logic [7:0]      r_op_a;
    logic [7:0]      r_op_b;
    logic [7:0]      r_out_y;
    logic            r_out_err;

    logic            w_push;
    logic            w_pop;
    logic            w_done;
    logic            w_tmo_hit;

    // Readiness uses the occupancy at the start of the cycle, so a full FIFO
    // refuses a push even when the FSM pops in the same cycle.
    assign IN_READY  = (r_count < c_DEPTH);
    assign w_push    = IN_VALID && IN_READY;
    assign w_pop     = (r_state == c_IDLE) && (r_count != 5'd0);
    assign w_done    = (r_state == c_WAIT) && GCD_DONE;

    assign PENDING   = r_count;
    assign GCD_START = (r_state == c_ISSUE);
    assign GCD_A     = r_op_a;
    assign GCD_B     = r_op_b;
    assign OUT_VALID = (r_state == c_HOLD);
    assign OUT_Y     = r_out_y;
    assign OUT_ERR   = r_out_err;

`ifdef GCD_DISPATCH_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_out_tmo;

    // The counter holds 254 during the 255th WAIT cycle; a missing DONE in
    // that cycle is the timeout. A DONE in the same cycle still wins.
    assign w_tmo_hit = (r_state == c_WAIT) && !GCD_DONE && (r_tmo_cnt == 8'd254);
    assign OUT_TMO   = r_out_tmo;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tmo_cnt <= 8'd0;
            r_out_tmo <= 1'b0;
        end else begin
            if (r_state == c_ISSUE) begin
                r_tmo_cnt <= 8'd0;
            end else if (r_state == c_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_done) begin
                r_out_tmo <= 1'b0;
            end else if (w_tmo_hit) begin
                r_out_tmo <= 1'b1;
            end
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign OUT_TMO   = 1'b0;
`endif

    // Operand storage carries no reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= IN_A;
            r_mem_b[r_wr_ptr] <= IN_B;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (r_count != 5'd0) w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = c_WAIT;
            c_WAIT:  if (GCD_DONE || w_tmo_hit) w_state_nxt = c_HOLD;
            c_HOLD:  if (OUT_READY) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op_a    <= 8'd0;
            r_op_b    <= 8'd0;
            r_out_y   <= 8'd0;
            r_out_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op_a <= r_mem_a[r_rd_ptr];
                r_op_b <= r_mem_b[r_rd_ptr];
            end
            if (w_done) begin
                // An erroring core may present garbage on GCD_Y; never pass it on.
                r_out_y   <= GCD_ERROR ? 8'h00 : GCD_Y;
                r_out_err <= GCD_ERROR;
            end else if (w_tmo_hit) begin
                r_out_y   <= 8'h00;
                r_out_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_dispatch
//  Purpose  : Self-checking bench for gcd_dispatch. Directed operand pairs
//             with hand-computed results feed a scoreboard; monitors compare
//             start pulses and results as the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcd_dispatch;

    logic       CLK;
    logic       RST;
    logic       IN_VALID;
    logic [7:0] IN_A;
    logic [7:0] IN_B;
    logic       IN_READY;
    logic       GCD_START;
    logic [7:0] GCD_A;
    logic [7:0] GCD_B;
    logic [7:0] GCD_Y;
    logic       GCD_DONE;
    logic       GCD_ERROR;
    logic       OUT_VALID;
    logic [7:0] OUT_Y;
    logic       OUT_ERR;
    logic       OUT_TMO;
    logic       OUT_READY;
    logic [4:0] PENDING;

    int checks    = 0;
    int failures  = 0;
    int n_results = 0;
    int cyc       = 0;

    logic [9:0]  exp_q[$];   // {tmo, err, y}
    logic [15:0] start_q[$]; // {a, b}

    bit model_en;
    bit model_stall;
    int model_lat;

    gcd_dispatch #(.DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .IN_READY  (IN_READY),
        .GCD_START (GCD_START),
        .GCD_A     (GCD_A),
        .GCD_B     (GCD_B),
        .GCD_Y     (GCD_Y),
        .GCD_DONE  (GCD_DONE),
        .GCD_ERROR (GCD_ERROR),
        .OUT_VALID (OUT_VALID),
        .OUT_Y     (OUT_Y),
        .OUT_ERR   (OUT_ERR),
        .OUT_TMO   (OUT_TMO),
        .OUT_READY (OUT_READY),
        .PENDING   (PENDING)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] f_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        while (y != 8'd0) begin
            t = y;
            y = x % y;
            x = t;
        end
        return x;
    endfunction

    // GCD core stand-in: latches operands on GCD_START, answers after
    // model_lat cycles unless stalled. Zero operands give an error with a
    // junk value on GCD_Y.
    initial begin : gcd_model
        logic [7:0] ma, mb;
        GCD_DONE  = 1'b0;
        GCD_ERROR = 1'b0;
        GCD_Y     = 8'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (GCD_START && model_en) begin
                ma = GCD_A;
                mb = GCD_B;
                repeat (model_lat) @(posedge CLK);
                while (model_stall) @(posedge CLK);
                #1;
                GCD_DONE  = 1'b1;
                GCD_ERROR = (ma == 8'd0) || (mb == 8'd0);
                GCD_Y     = GCD_ERROR ? 8'hA5 : f_gcd(ma, mb);
                @(posedge CLK);
                #1;
                GCD_DONE  = 1'b0;
                GCD_ERROR = 1'b0;
                GCD_Y     = 8'd0;
            end
        end
    end

    // Scoreboard monitors: a result is taken on every OUT_VALID && OUT_READY
    // cycle, a start on every GCD_START cycle.
    always @(negedge CLK) begin : monitor
        logic [9:0]  e;
        logic [15:0] s;
        if (!RST && OUT_VALID && OUT_READY) begin
            n_results++;
            chk("result_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_y",   OUT_Y,   e[7:0]);
                chk("out_err", OUT_ERR, e[8]);
                chk("out_tmo", OUT_TMO, e[9]);
            end
        end
        if (!RST && GCD_START) begin
            chk("start_expected", int'(start_q.size() > 0), 1);
            if (start_q.size() > 0) begin
                s = start_q.pop_front();
                chk("gcd_a", GCD_A, s[15:8]);
                chk("gcd_b", GCD_B, s[7:0]);
            end
        end
    end

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] y, input logic err, input logic tmo,
                             input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1;
            IN_A     = a;
            IN_B     = b;
            if (IN_READY) begin
                ok = 1'b1;
                exp_q.push_back({tmo, err, y});
                start_q.push_back({a, b});
            end
            @(posedge CLK);
            #1;
            IN_VALID = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge CLK);
        chk(name, exp_q.size(), 0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_q.delete();
        start_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    int tv_a [5] = '{35, 100, 17, 48, 255};
    int tv_b [5] = '{21,  75,  5, 36,  85};
    int tv_y [5] = '{ 7,  25,  1, 12,  85};
    int st_a [6] = '{ 8,   9, 14, 50, 81, 3};
    int st_b [6] = '{12,  27, 21, 20, 54, 7};
    int st_y [6] = '{ 4,   9,  7, 10, 27, 1};

    initial begin : stimulus
        bit ok;
        int n_before;
        int t0;

        RST         = 1'b1;
        IN_VALID    = 1'b0;
        IN_A        = 8'd0;
        IN_B        = 8'd0;
        OUT_READY   = 1'b1;
        model_en    = 1'b1;
        model_stall = 1'b0;
        model_lat   = 2;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_pending",   PENDING,   0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_gcd_start", GCD_START, 0);
        chk("rst_out_y",     OUT_Y,     0);
        chk("rst_out_err",   OUT_ERR,   0);
        chk("rst_out_tmo",   OUT_TMO,   0);
        chk("rst_gcd_a",     GCD_A,     0);
        chk("rst_gcd_b",     GCD_B,     0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("in_ready_after_rst", IN_READY, 1);

        // Basic pair and start latency: push edge N, start during cycle N+2
        push_pair(8'd12, 8'd18, 8'd6, 1'b0, 1'b0, 4, ok);
        chk("push_12_18_accepted", ok, 1);
        chk("start_cycle_n1", GCD_START, 0);
        @(posedge CLK);
        #1;
        chk("start_cycle_n2", GCD_START, 1);
        chk("start_n2_a", GCD_A, 12);
        chk("start_n2_b", GCD_B, 18);
        @(posedge CLK);
        #1;
        chk("start_cycle_n3", GCD_START, 0);
        wait_drain("drain_basic", 50);

        // Zero operand -> error result with value forced to 0
        push_pair(8'd0, 8'd9, 8'd0, 1'b1, 1'b0, 4, ok);
        chk("push_0_9_accepted", ok, 1);
        wait_drain("drain_error", 50);

        // Several vectors back-to-back with varying core latency
        for (int i = 0; i < 5; i++) begin
            model_lat = (i % 3) + 1;
            push_pair(8'(tv_a[i]), 8'(tv_b[i]), 8'(tv_y[i]), 1'b0, 1'b0, 20, ok);
            chk("push_vec_accepted", ok, 1);
        end
        wait_drain("drain_vectors", 200);

        // Stalled core: 5 of 6 pairs accepted, full FIFO refuses the sixth
        model_lat   = 1;
        model_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_pair(8'(st_a[i]), 8'(st_b[i]), 8'(st_y[i]), 1'b0, 1'b0, 1, ok);
            chk("stall_push_accepted", ok, 1);
        end
        chk("stall_pending_full", PENDING, 4);
        chk("stall_in_ready_low", IN_READY, 0);
        push_pair(8'(st_a[5]), 8'(st_b[5]), 8'(st_y[5]), 1'b0, 1'b0, 3, ok);
        chk("stall_sixth_rejected", ok, 0);
        chk("stall_pending_still_full", PENDING, 4);
        model_stall = 1'b0;
        wait_drain("drain_stall", 300);

        // Consumer back-pressure holds result 7 steady
        model_lat = 2;
        OUT_READY = 1'b0;
        push_pair(8'd7, 8'd14, 8'd7, 1'b0, 1'b0, 4, ok);
        for (int i = 0; i < 50 && !OUT_VALID; i++) @(negedge CLK);
        chk("hold_valid_seen", OUT_VALID, 1);
        push_pair(8'd20, 8'd30, 8'd10, 1'b0, 1'b0, 4, ok);
        chk("hold_queue_push", ok, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("hold_valid",   OUT_VALID, 1);
            chk("hold_y",       OUT_Y,     7);
            chk("hold_err",     OUT_ERR,   0);
            chk("hold_no_start", GCD_START, 0);
            chk("hold_pending", PENDING,   1);
        end
        n_before = n_results;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        chk("hold_single_transfer", n_results, n_before + 1);
        chk("hold_valid_cleared", OUT_VALID, 0);
        wait_drain("drain_hold", 100);

        // Reset during WAIT with two queued pairs
        model_stall = 1'b1;
        push_pair(8'd8,  8'd4,  8'd4, 1'b0, 1'b0, 4, ok);
        push_pair(8'd6,  8'd9,  8'd3, 1'b0, 1'b0, 4, ok);
        push_pair(8'd10, 8'd15, 8'd5, 1'b0, 1'b0, 4, ok);
        repeat (2) @(posedge CLK);
        #1;
        chk("prereset_pending", PENDING, 2);
        chk("prereset_out_valid", OUT_VALID, 0);
        do_reset();
        chk("postreset_pending", PENDING, 0);
        chk("postreset_out_valid", OUT_VALID, 0);
        chk("postreset_gcd_start", GCD_START, 0);
        chk("postreset_in_ready", IN_READY, 1);
        n_before    = n_results;
        model_stall = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        chk("late_done_no_result", n_results, n_before);
        chk("late_done_out_valid", OUT_VALID, 0);
        chk("late_done_pending", PENDING, 0);

        // Core that never answers
        model_en = 1'b0;
        n_before = n_results;
`ifdef GCD_DISPATCH_TIMEOUT_EN
        push_pair(8'd5, 8'd10, 8'd0, 1'b1, 1'b1, 4, ok);
        for (int i = 0; i < 20 && !GCD_START; i++) @(negedge CLK);
        chk("tmo_start_seen", GCD_START, 1);
        t0 = cyc;
        for (int i = 0; i < 400 && !OUT_VALID; i++) @(negedge CLK);
        chk("tmo_valid_seen", OUT_VALID, 1);
        chk("tmo_latency", cyc - t0, 256);
        wait_drain("drain_tmo", 20);
`else
        push_pair(8'd5, 8'd10, 8'd0, 1'b1, 1'b1, 4, ok);
        t0 = cyc;
        repeat (1000) @(posedge CLK);
        #1;
        chk("no_tmo_no_result", n_results, n_before);
        chk("no_tmo_out_valid", OUT_VALID, 0);
        chk("no_tmo_still_waiting", exp_q.size(), 1);
        chk("no_tmo_elapsed", int'(cyc - t0 >= 1000), 1);
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcd_dispatch.md
GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, operand-FIFO entries; power of two, 2..16.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 IN_VALID  in  1  upstream offers operand pair.
REQ-005 IN_A / IN_B  in  8 each  operand pair.
REQ-006 IN_READY  out  1  FIFO can accept; a pair is pushed when IN_VALID && IN_READY.
REQ-007 GCD_START  out  1  one-cycle start pulse to the downstream GCD core.
REQ-008 GCD_A / GCD_B  out  8 each  operands to the GCD core, valid while GCD_START=1.
REQ-009 GCD_Y  in  8  GCD core result.
REQ-010 GCD_DONE  in  1  GCD core result-valid pulse.
REQ-011 GCD_ERROR  in  1  GCD core error flag (zero operand), valid with GCD_DONE.
REQ-012 OUT_VALID  out  1  result held for consumer.
REQ-013 OUT_Y  out  8  result value.
REQ-014 OUT_ERR  out  1  result is an error.
REQ-015 OUT_TMO  out  1  error caused by timeout (REQ-034).
REQ-016 OUT_READY  in  1  consumer accepts; transfer when OUT_VALID && OUT_READY.
REQ-017 PENDING  out  5  FIFO occupancy, 0..DEPTH.

Function
REQ-018 FIFO: circular, pointers wrap modulo DEPTH; IN_READY = (PENDING < DEPTH), computed from current-cycle occupancy, so no push when full even if a pop occurs that cycle.
REQ-019 Simultaneous push and pop: occupancy unchanged, both take effect.
REQ-020 FSM states IDLE, ISSUE, WAIT, HOLD; all outputs registered or decoded from the state register only.
REQ-021 IDLE: if PENDING>0, pop head into operand registers, go ISSUE; else stay.
REQ-022 ISSUE: GCD_START=1 for exactly this cycle, GCD_A/GCD_B = operand registers; next state WAIT.
REQ-023 GCD_A/GCD_B hold operand registers in all states; GCD_START=0 outside ISSUE.
REQ-024 WAIT: on GCD_DONE=1 capture OUT_Y=GCD_Y, OUT_ERR=GCD_ERROR, OUT_TMO=0, set OUT_VALID=1, go HOLD.
REQ-025 If GCD_ERROR=1 at capture, OUT_Y=8'h00 (never forward an undefined value).
REQ-026 HOLD: OUT_VALID, OUT_Y, OUT_ERR, OUT_TMO stable until OUT_READY=1; on transfer clear OUT_VALID, go IDLE.
REQ-027 GCD_DONE outside WAIT is ignored.
REQ-028 At most one operation in flight; results returned in push order.
REQ-029 Latency, empty FIFO, idle FSM: push at edge N, GCD_START high during cycle N+2 (edge N+1 pops into IDLE->ISSUE).
REQ-030 FIFO continues accepting pushes in every FSM state.

Reset
REQ-031 RST=1 at an edge: FSM->IDLE, FIFO emptied (pointers, PENDING=0), operand registers 0, GCD_START=0, OUT_VALID=0, OUT_Y=0, OUT_ERR=0, OUT_TMO=0, timeout counter 0.
REQ-032 Reset mid-operation drops in-flight and queued pairs without producing a result; GCD_DONE during the following IDLE is ignored.
REQ-033 IN_READY=1 in the first cycle after reset release (DEPTH>0).

Configuration
REQ-034 Macro GCD_DISPATCH_TIMEOUT_EN defined: 8-bit counter cleared in ISSUE, increments each WAIT cycle; if it reaches 255 without GCD_DONE, go HOLD with OUT_VALID=1, OUT_Y=0, OUT_ERR=1, OUT_TMO=1; GCD_DONE in that same cycle takes priority.
REQ-035 Macro undefined: no counter, WAIT waits indefinitely, OUT_TMO tied 0.

Verification
REQ-036 Push (12,18), OUT_READY=1, GCD model -> one GCD_START pulse with A=12,B=18 in cycle N+2, result OUT_Y=6, OUT_ERR=0.
REQ-037 Push (0,9) -> model returns ERROR=1 -> OUT_ERR=1, OUT_Y=0.
REQ-038 DEPTH=4, GCD stalled, push 6 pairs back-to-back -> 5 accepted (1 in flight + 4 queued), IN_READY=0 while PENDING=4; results later emerge in push order.
REQ-039 OUT_READY=0 for 10 cycles after OUT_VALID with result 7 -> outputs stable, no new GCD_START, single transfer once OUT_READY=1.
REQ-040 RST pulse during WAIT with 2 pairs queued -> PENDING=0, OUT_VALID=0, late GCD_DONE produces no result.
REQ-041 With GCD_DISPATCH_TIMEOUT_EN, model never asserts DONE -> OUT_VALID after 255 WAIT cycles with OUT_ERR=1, OUT_TMO=1, OUT_Y=0; without macro, no result after 1000 cycles.
